// File: rtl/bus_arbiter_pkg.sv
// Shared types and helpers for the four-way round-robin bus arbiter.
// State encodings, requester count and the rotating priority pick live here.
package bus_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    // First set request bit scanning ptr, ptr+1, ... modulo NUM_REQ.
    function automatic logic [SEL_W-1:0] rr_pick(
        input logic [NUM_REQ-1:0] req,
        input logic [SEL_W-1:0]   ptr
    );
        logic [SEL_W-1:0] idx;
        logic [SEL_W-1:0] pick;
        logic             found;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ptr + SEL_W'(k);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/fourOneMux.sv
// 4:1 data mux with an output enable; disabled output is all zeros.
// Built as masked lanes OR-reduced so each lane is an independent and-gate.
module fourOneMux
    import bus_arbiter_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    input  logic [W-1:0]     d0,
    input  logic [W-1:0]     d1,
    input  logic [W-1:0]     d2,
    input  logic [W-1:0]     d3,
    output logic [W-1:0]     y
);

    logic [W-1:0] lanes  [NUM_REQ];
    logic [W-1:0] masked [NUM_REQ];

    assign lanes[0] = d0;
    assign lanes[1] = d1;
    assign lanes[2] = d2;
    assign lanes[3] = d3;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            assign masked[gi] = (en && (sel == SEL_W'(gi))) ? lanes[gi] : '0;
        end
    endgenerate

    assign y = masked[0] | masked[1] | masked[2] | masked[3];

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of the 8-bit internal data bus with a bounded hold time.
// One idle turnaround cycle always separates consecutive owners.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 8
) (
    input  logic               clk,
    input  logic               rstN,
    input  logic [NUM_REQ-1:0] req,
    input  logic [7:0]         dIn0,
    input  logic [7:0]         dIn1,
    input  logic [7:0]         dIn2,
    input  logic [7:0]         dIn3,
    output logic [NUM_REQ-1:0] grant,
    output logic [SEL_W-1:0]   sel,
    output logic               busValid,
    output logic [7:0]         busData,
    output logic               timeout
);

    generate
        if (MAX_HOLD < 1 || MAX_HOLD > 255 || (64'd1 << HOLD_W) <= 64'(MAX_HOLD)) begin : g_bad_param
            $error("bus_arbiter: MAX_HOLD out of range or HOLD_W too narrow");
        end
    endgenerate

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t            state_reg;
    logic [SEL_W-1:0]  ptr_reg;
    logic [HOLD_W-1:0] hold_reg;

    logic [SEL_W-1:0]  winner;
    logic              owner_req;
    logic              at_limit;

    assign winner    = rr_pick(req, ptr_reg);
    assign owner_req = req[sel];
    assign at_limit  = (hold_reg == HOLD_LAST);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            hold_reg  <= '0;
            grant     <= '0;
            sel       <= '0;
            busValid  <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req != '0) begin
                        state_reg <= OWNED;
                        grant     <= NUM_REQ'(1) << winner;
                        sel       <= winner;
                        busValid  <= 1'b1;
                        hold_reg  <= '0;
                    end
                end
                OWNED: begin
                    if (!owner_req || at_limit) begin
                        state_reg <= IDLE;
                        grant     <= '0;
                        busValid  <= 1'b0;
                        ptr_reg   <= sel + SEL_W'(1);
                        // A drop coinciding with the limit is a normal release.
                        timeout   <= owner_req && at_limit;
                    end else begin
                        hold_reg <= hold_reg + HOLD_W'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    grant     <= '0;
                    busValid  <= 1'b0;
                end
            endcase
        end
    end

    fourOneMux #(.W(8)) u_mux (
        .sel (sel),
        .en  (busValid),
        .d0  (dIn0),
        .d1  (dIn1),
        .d2  (dIn2),
        .d3  (dIn3),
        .y   (busData)
    );

    a_grant_onehot : assert property (@(posedge clk) disable iff (!rstN) $onehot0(grant));
    a_grant_valid  : assert property (@(posedge clk) disable iff (!rstN) ((grant != '0) == busValid));
    a_sel_matches  : assert property (@(posedge clk) disable iff (!rstN) (busValid -> grant[sel]));

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: expected bus snapshots are queued with
// the stimulus and popped one per clock when the DUT output is sampled.
module tb_bus_arbiter;

    typedef struct packed {
        logic [3:0] grant;
        logic [1:0] sel;
        logic       valid;
        logic       to;
        logic [7:0] data;
    } obs_t;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic [3:0] req = 4'h0;
    logic [7:0] d_in [4];
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busValid;
    logic [7:0] busData;
    logic       timeout;

    logic [7:0] dval [4];
    obs_t       exp_q [$];
    obs_t       obs;
    obs_t       e;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.MAX_HOLD(8), .HOLD_W(8)) dut (
        .clk      (clk),
        .rstN     (rstN),
        .req      (req),
        .dIn0     (d_in[0]),
        .dIn1     (d_in[1]),
        .dIn2     (d_in[2]),
        .dIn3     (d_in[3]),
        .grant    (grant),
        .sel      (sel),
        .busValid (busValid),
        .busData  (busData),
        .timeout  (timeout)
    );

    assign obs = {grant, sel, busValid, timeout, busData};

    function automatic obs_t owned(input int idx);
        obs_t o;
        o.grant = 4'b0001 << idx;
        o.sel   = 2'(idx);
        o.valid = 1'b1;
        o.to    = 1'b0;
        o.data  = dval[idx];
        return o;
    endfunction

    function automatic obs_t idle(input int idx, input logic to);
        obs_t o;
        o.grant = 4'b0000;
        o.sel   = 2'(idx);
        o.valid = 1'b0;
        o.to    = to;
        o.data  = 8'h00;
        return o;
    endfunction

    task automatic do_reset();
        @(posedge clk);
        #1;
        req  = 4'h0;
        rstN = 1'b0;
        #2;
        rstN = 1'b1;
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        req  = 4'hF;
        exp_q.push_back(idle(0, 1'b0));
        exp_q.push_back(idle(0, 1'b0));
        exp_q.push_back(owned(2));
        exp_q.push_back(idle(2, 1'b0));
        #2;
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL reset_async: got %h want %h", obs, e);
        end else $display("ok   reset_async: %h", obs);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL reset_held: got %h want %h", obs, e);
        end else $display("ok   reset_held: %h", obs);
        rstN = 1'b1;
        req  = 4'h4;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            req = 4'h0;
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL reset_first_grant cyc %0d: got %h want %h", i, obs, e);
            end else $display("ok   reset_first_grant cyc %0d: %h", i, obs);
        end
    endtask

    task automatic test_round_robin();
        int owners [5] = '{0, 1, 2, 3, 0};
        do_reset();
        foreach (owners[k]) begin
            for (int c = 0; c < 8; c++) exp_q.push_back(owned(owners[k]));
            exp_q.push_back(idle(owners[k], 1'b1));
        end
        req = 4'hF;
        for (int i = 0; i < 45; i++) begin
            @(posedge clk);
            #1;
            if (i == 44) req = 4'h0;
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL round_robin cyc %0d: got %h want %h", i, obs, e);
            end else $display("ok   round_robin cyc %0d: %h", i, obs);
        end
    endtask

    task automatic test_early_release();
        logic [3:0] seq [6] = '{4'h1, 4'h1, 4'h1, 4'h8, 4'h9, 4'h0};
        do_reset();
        for (int c = 0; c < 3; c++) exp_q.push_back(owned(0));
        exp_q.push_back(idle(0, 1'b0));
        exp_q.push_back(owned(3));
        exp_q.push_back(idle(3, 1'b0));
        for (int i = 0; i < 6; i++) begin
            req = seq[i];
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL early_release cyc %0d: got %h want %h", i, obs, e);
            end else $display("ok   early_release cyc %0d: %h", i, obs);
        end
        req = 4'h0;
    endtask

    task automatic test_drop_at_limit();
        do_reset();
        for (int c = 0; c < 8; c++) exp_q.push_back(owned(1));
        exp_q.push_back(idle(1, 1'b0));
        for (int i = 0; i < 9; i++) begin
            req = (i < 8) ? 4'h2 : 4'h0;
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL drop_at_limit cyc %0d: got %h want %h", i, obs, e);
            end else $display("ok   drop_at_limit cyc %0d: %h", i, obs);
        end
    endtask

    task automatic test_async_reset_mid_grant();
        do_reset();
        exp_q.push_back(owned(3));
        exp_q.push_back(owned(3));
        exp_q.push_back(idle(0, 1'b0));
        req = 4'h8;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL mid_grant_owned cyc %0d: got %h want %h", i, obs, e);
            end else $display("ok   mid_grant_owned cyc %0d: %h", i, obs);
        end
        #2;
        rstN = 1'b0;
        #1;
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL mid_grant_async_reset: got %h want %h", obs, e);
        end else $display("ok   mid_grant_async_reset: %h", obs);
        req = 4'h0;
        #1;
        rstN = 1'b1;
    endtask

    task automatic test_isolation();
        do_reset();
        for (int c = 0; c < 7; c++) exp_q.push_back(owned(3));
        req = 4'h8;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL isolation cyc %0d: got %h want %h", i, obs, e);
            end else $display("ok   isolation cyc %0d: %h", i, obs);
            for (int j = 0; j < 3; j++) d_in[j] = 8'($urandom);
        end
        req = 4'h0;
        for (int j = 0; j < 4; j++) d_in[j] = dval[j];
        @(posedge clk);
        #1;
    endtask

    initial begin
        dval[0] = 8'h3C;
        dval[1] = 8'h5A;
        dval[2] = 8'hA5;
        dval[3] = 8'hC3;
        for (int j = 0; j < 4; j++) d_in[j] = dval[j];
        test_reset();
        test_round_robin();
        test_early_release();
        test_drop_at_limit();
        test_async_reset_mid_grant();
        test_isolation();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
